// File: rtl/tb_mem_pkg.sv
// Shared types and width helpers for the testbench SRAM arbiter.
package tb_mem_pkg;

  localparam int DefAddrWidth = 15;
  localparam int DefDataWidth = 64;

  typedef struct packed {
    logic                      we;
    logic [DefAddrWidth-1:0]   addr;
    logic [DefDataWidth/8-1:0] be;
    logic [DefDataWidth-1:0]   wdata;
  } mem_req_t;

  function automatic int port_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lock_cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tb_rr_arbiter.sv
// Combinational round-robin picker with a lock override.
module tb_rr_arbiter
  import tb_mem_pkg::*;
#(
  parameter int NumPorts = 2,
  parameter int IdxW     = port_idx_width(NumPorts)
) (
  input  logic [NumPorts-1:0] req,
  input  logic [IdxW-1:0]     rr_ptr,
  input  logic [NumPorts-1:0] lock_ovr,
  output logic [NumPorts-1:0] gnt,
  output logic [IdxW-1:0]     gnt_idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    if (|(lock_ovr & req)) begin
      for (int k = 0; k < NumPorts; k++) begin
        if (lock_ovr[k]) begin
          gnt[k]  = 1'b1;
          gnt_idx = IdxW'(k);
        end
      end
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        cand = IdxW'((int'(rr_ptr) + i) % NumPorts);
        if (!found && req[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter with bounded lock sharing one 1-cycle SRAM.
module tb_mem_arbiter
  import tb_mem_pkg::*;
#(
  parameter int NumPorts  = 2,
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int MaxLock   = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts-1:0]             lock_i,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts*DataWidth/8-1:0] be_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  output logic [NumPorts-1:0]             gnt_o,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic [DataWidth/8-1:0]          mem_be_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  input  logic [DataWidth-1:0]            mem_rdata_i
);

  localparam int IdxW = port_idx_width(NumPorts);
  localparam int CntW = lock_cnt_width(MaxLock);
  localparam int BeW  = DataWidth / 8;

  logic [IdxW-1:0]     rr_ptr, rr_ptr_d;
  logic [IdxW-1:0]     lock_owner, lock_owner_d;
  logic                lock_active, lock_active_d;
  logic [CntW-1:0]     lock_cnt, lock_cnt_d, cnt_eff;
  logic [CntW:0]       cnt_nxt;
  logic [NumPorts-1:0] lock_ovr, gnt_raw, rvalid_q;
  logic [IdxW-1:0]     gnt_idx;
  logic                lock_hit;
  mem_req_t            sel;

  always_comb begin
    lock_ovr = '0;
    if (lock_active) lock_ovr[lock_owner] = 1'b1;
  end

  tb_rr_arbiter #(
    .NumPorts (NumPorts),
    .IdxW     (IdxW)
  ) u_rr (
    .req      (req_i),
    .rr_ptr   (rr_ptr),
    .lock_ovr (lock_ovr),
    .gnt      (gnt_raw),
    .gnt_idx  (gnt_idx)
  );

  assign gnt_o     = rst_i ? '0 : gnt_raw;
  assign mem_req_o = |gnt_o;
  assign lock_hit  = |(lock_ovr & req_i);

  always_comb begin
    sel = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (gnt_o[k]) begin
        sel.we    = we_i[k];
        sel.addr  = DefAddrWidth'(addr_i[k*AddrWidth +: AddrWidth]);
        sel.be    = (DefDataWidth/8)'(be_i[k*BeW +: BeW]);
        sel.wdata = DefDataWidth'(wdata_i[k*DataWidth +: DataWidth]);
      end
    end
  end

  assign mem_we_o    = sel.we;
  assign mem_addr_o  = AddrWidth'(sel.addr);
  assign mem_be_o    = BeW'(sel.be);
  assign mem_wdata_o = DataWidth'(sel.wdata);

  // A lock whose owner went idle no longer counts toward the bound.
  assign cnt_eff = lock_hit ? lock_cnt : '0;
  assign cnt_nxt = {1'b0, cnt_eff} + 1'b1;

  always_comb begin
    rr_ptr_d      = rr_ptr;
    lock_owner_d  = lock_owner;
    lock_active_d = lock_active;
    lock_cnt_d    = lock_cnt;
    if (mem_req_o) begin
      if (lock_i[gnt_idx] && (cnt_nxt < (CntW+1)'(MaxLock))) begin
        lock_active_d = 1'b1;
        lock_owner_d  = gnt_idx;
        lock_cnt_d    = cnt_nxt[CntW-1:0];
      end else begin
        lock_active_d = 1'b0;
        lock_cnt_d    = '0;
        rr_ptr_d      = (int'(gnt_idx) == NumPorts-1) ? '0
                                                      : gnt_idx + 1'b1;
      end
    end else if (lock_active && !req_i[lock_owner]) begin
      lock_active_d = 1'b0;
      lock_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      lock_owner  <= '0;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      rvalid_q    <= '0;
    end else begin
      rr_ptr      <= rr_ptr_d;
      lock_owner  <= lock_owner_d;
      lock_active <= lock_active_d;
      lock_cnt    <= lock_cnt_d;
      rvalid_q    <= gnt_o;
    end
  end

  assign rvalid_o = rst_i ? '0 : rvalid_q;
  assign rdata_o  = mem_rdata_i;

  logic [NumPorts-1:0] wait_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) wait_q <= '0;
    else       wait_q <= req_i & ~gnt_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(gnt_o))
        else $error("gnt_o not one-hot: %b", gnt_o);
      assert ($onehot0(rvalid_o))
        else $error("rvalid_o not one-hot: %b", rvalid_o);
      assert ((wait_q & ~req_i) == '0)
        else $error("req dropped before gnt: %b", wait_q & ~req_i);
    end
  end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Directed scoreboard bench for the SRAM arbiter.
module tb_tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req, we, lock;
  logic [14:0]  a0, a1;
  logic [7:0]   b0, b1;
  logic [63:0]  w0, w1;
  logic [1:0]   gnt_o, rvalid_o;
  logic [63:0]  rdata_o;
  logic         mem_req, mem_we;
  logic [14:0]  mem_addr;
  logic [7:0]   mem_be;
  logic [63:0]  mem_wdata, mem_rdata;

  logic [63:0]  mem [0:32767];

  typedef struct packed {
    logic [1:0]  rv;
    logic        chk;
    logic [63:0] d;
  } resp_t;

  resp_t sb[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tb_mem_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .lock_i      (lock),
    .addr_i      ({a1, a0}),
    .be_i        ({b1, b0}),
    .wdata_i     ({w1, w0}),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [1:0] eg,
                     input logic rd, input logic [63:0] ed);
    resp_t e;
    @(negedge clk);
    check({tag, "_gnt"}, 64'(gnt_o), 64'(eg));
    check({tag, "_mreq"}, 64'(mem_req), 64'(|eg));
    e = sb.pop_front();
    if (rst) e = '0;
    check({tag, "_rvalid"}, 64'(rvalid_o), 64'(e.rv));
    if (e.chk) check({tag, "_rdata"}, rdata_o, e.d);
    sb.push_back('{rv: eg, chk: rd, d: ed});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 2'b11; we = 2'b00; lock = 2'b00;
    a0 = '0; a1 = 15'd1; b0 = 8'hFF; b1 = 8'hFF;
    w0 = '0; w1 = '0;
    sb.push_back('0);

    cyc("rst0", 2'b00, 1'b0, 64'd0);
    cyc("rst1", 2'b00, 1'b0, 64'd0);
    rst = 1'b0;

    cyc("ct0", 2'b01, 1'b0, 64'd0);
    cyc("ct1", 2'b10, 1'b0, 64'd0);
    cyc("ct2", 2'b01, 1'b0, 64'd0);
    cyc("ct3", 2'b10, 1'b0, 64'd0);
    cyc("ct4", 2'b01, 1'b0, 64'd0);
    req = 2'b10;
    cyc("ct5", 2'b10, 1'b0, 64'd0);

    req = 2'b10; we = 2'b10; a1 = 15'h800; b1 = 8'hFF; w1 = 64'h539;
    #3;
    check("wr_mwe", 64'(mem_we), 64'd1);
    check("wr_maddr", 64'(mem_addr), 64'h800);
    check("wr_mwdata", mem_wdata, 64'h539);
    check("wr_mbe", 64'(mem_be), 64'hFF);
    cyc("wr", 2'b10, 1'b0, 64'd0);
    we = 2'b00;
    cyc("rd", 2'b10, 1'b1, 64'h539);
    req = 2'b00;
    cyc("rd_idle", 2'b00, 1'b0, 64'd0);

    req = 2'b11; lock = 2'b01; a0 = 15'h10; a1 = 15'h800;
    for (int i = 0; i < 8; i++) cyc($sformatf("lk%0d", i), 2'b01, 1'b0, 64'd0);
    check("lk_rr_ptr", 64'(dut.rr_ptr), 64'd1);
    check("lk_cnt0", 64'(dut.lock_cnt), 64'd0);
    cyc("lk_rel", 2'b10, 1'b1, 64'h539);
    req = 2'b01; lock = 2'b00;
    cyc("lk_tail", 2'b01, 1'b0, 64'd0);

    req = 2'b01; lock = 2'b01;
    cyc("own", 2'b01, 1'b0, 64'd0);
    check("own_cnt", 64'(dut.lock_cnt), 64'd1);
    check("own_act", 64'(dut.lock_active), 64'd1);
    req = 2'b10; lock = 2'b00;
    cyc("own_idle", 2'b10, 1'b1, 64'h539);
    check("own_cnt0", 64'(dut.lock_cnt), 64'd0);
    check("own_act0", 64'(dut.lock_active), 64'd0);

    req = 2'b10; lock = 2'b10;
    cyc("mid_rd", 2'b10, 1'b1, 64'h539);
    check("mid_cnt", 64'(dut.lock_cnt), 64'd1);
    rst = 1'b1; req = 2'b00; lock = 2'b00;
    cyc("mid_rst", 2'b00, 1'b0, 64'd0);
    rst = 1'b0;
    check("mid_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    check("mid_cnt0", 64'(dut.lock_cnt), 64'd0);
    check("mid_act0", 64'(dut.lock_active), 64'd0);
    req = 2'b11;
    cyc("post0", 2'b01, 1'b0, 64'd0);
    req = 2'b10;
    cyc("post1", 2'b10, 1'b1, 64'h539);
    req = 2'b00;
    cyc("post_idle", 2'b00, 1'b0, 64'd0);
    cyc("post_idle2", 2'b00, 1'b0, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tb_mem_arbiter.md
Name: tb_mem_arbiter

Overview:
- Shares one single-port testbench SRAM (1-cycle read latency) between NumPorts requesters, e.g. the core's AXI-to-memory bridge and a DMI-driven preload/inspect port.
- Round-robin arbitration with an optional bounded lock, so a requester can finish back-to-back accesses without starving the others.
- Sits between the requesters' req/we/addr/be/wdata interfaces and the SRAM instance inside the testbench top.

Parameters:
- NumPorts, 2, number of requesters; must be at least 2.
- AddrWidth, 15, SRAM word-address width (clog2 of 32768 words).
- DataWidth, 64, data width in bits; byte-enable width is DataWidth/8.
- MaxLock, 8, maximum consecutive locked grants to one port before a forced release; must be at least 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumPorts  per-port request; held with its payload stable until gnt_o.
- we_i  in  NumPorts  per-port write enable.
- lock_i  in  NumPorts  per-port lock hint; sampled only on the cycle that port is granted.
- addr_i  in  NumPorts*AddrWidth  per-port word addresses, port k at bits [k*AddrWidth +: AddrWidth].
- be_i  in  NumPorts*DataWidth/8  per-port byte enables, flattened the same way.
- wdata_i  in  NumPorts*DataWidth  per-port write data, flattened the same way.
- gnt_o  out  NumPorts  one-hot grant, same cycle as the accepted request.
- rvalid_o  out  NumPorts  one-hot response valid, one cycle after the grant.
- rdata_o  out  DataWidth  read data, broadcast to all ports; meaningful only with rvalid_o.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  AddrWidth  SRAM word address.
- mem_be_o  out  DataWidth/8  SRAM byte enables.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read request.

Behaviour:
- Reset (rst_i=1, synchronous): rr_ptr=0, lock_active=0, lock_owner=0, lock_cnt=0, rvalid_o=0. While rst_i=1, gnt_o=0 and mem_req_o=0 regardless of req_i. An rvalid in flight when reset asserts is dropped.
- Grant selection is combinational:
  - If lock_active and req_i[lock_owner]=1, grant lock_owner.
  - Otherwise grant the first requesting port found searching upward from rr_ptr, modulo NumPorts.
  - If no port requests, gnt_o=0 and mem_req_o=0.
- Memory mux: when port k is granted, mem_req_o=1 and mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o equal port k's fields. When idle, mem_* data outputs are 0.
- Response: rvalid_o <= gnt_o, registered, for both reads and writes; a write response is an acknowledge.
  - rdata_o = mem_rdata_i, combinational pass-through.
  - Throughput is one access per cycle.
  - Back-to-back grants to different ports give back-to-back one-hot rvalid.
- Lock and round-robin update on each grant to port k:
  - If lock_i[k]=1 and lock_cnt+1 < MaxLock: lock_active<=1, lock_owner<=k, lock_cnt<=lock_cnt+1; rr_ptr unchanged.
  - Otherwise: lock_active<=0, lock_cnt<=0, rr_ptr<=(k+1) mod NumPorts. This covers a forced release at MaxLock.
  - If lock_active and the owner does not request: lock released (lock_active<=0, lock_cnt<=0) and normal round-robin applies in the same cycle.
- No-grant cycle: rr_ptr holds.
- Counter widths: lock_cnt is clog2(MaxLock+1) bits; rr_ptr is clog2(NumPorts) bits, wrapping from NumPorts-1 to 0.
- Simultaneous requests with no lock: exactly one grant; others wait with req held.
- Checks in simulation only:
  - gnt_o and rvalid_o are one-hot-or-zero.
  - A requester dropping req_i before gnt_o is flagged as a protocol error.

Decomposition:
- Shared package tb_mem_pkg holds:
  - typedef mem_req_t {we, addr, be, wdata};
  - PortIdxWidth and LockCntWidth derivation functions;
  - default AddrWidth and DataWidth constants.
- One natural sub-module: tb_rr_arbiter. It takes req, rr_ptr and the lock-override vector and returns a one-hot grant plus its index, purely combinationally.
- The top holds the pointer, lock state, response register and data mux.

Test Plan:
- Reset: rst_i=1 with req_i=2'b11 -> gnt_o=0, mem_req_o=0, rvalid_o=0. First cycle after release -> gnt_o=2'b01 (rr_ptr=0).
- Contention: both ports request continuously, no lock, 6 cycles -> grants alternate 01,10,01,10,01,10; rvalid_o repeats that sequence one cycle later.
- Read path: port1 writes addr 0x800, data 64'h539, be=8'hFF, then reads 0x800 -> rvalid_o=2'b10 the cycle after the read grant, rdata_o=64'h539.
- Lock bound: MaxLock=8, port0 holds lock_i=1 while both request -> port0 granted 8 consecutive times, then port1 granted; rr_ptr=1 after the forced release.
- Lock release by idle owner: port0 locks once, then drops req_i while port1 requests -> port1 granted in that same cycle; lock_cnt returns to 0.
- Reset mid-flight: read granted to port1, rst_i asserted the next cycle -> rvalid_o=0 in that cycle; rr_ptr=0 after reset.
